// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and instruction-bus sequencer in front of fetch/decode.
// Presents one registered instruction (pc, instr, valid) at a time, holds it
// under stall and drops stale in-flight fetches on execute redirects.
// Optional build macro: FETCH_MISALIGN_TRAP_EN. When defined, a redirect to a
// target with pc[1:0]!=0 is not fetched; a misaligned-fetch marker entry is
// presented instead. When undefined, redirect_pc[1:0] is forced to 2'b00 and
// out_misalign is constant 0.
//
// Handshake: ireq_valid/ireq_addr form a request that stays stable until the
// single-cycle iresp_data_ok pulse; at most one request is ever outstanding and
// a data_ok outside FETCH/DRAIN is ignored. out_valid marks a live entry that is
// consumed on any cycle where it is high and stall is low.
module fetch_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign,
    output logic [1:0]  dbg_state
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DRAIN   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [63:0] req_addr, req_addr_n;
    logic [63:0] next_pc, next_pc_n;
    logic        out_valid_n;
    logic [63:0] out_pc_n;
    logic [31:0] out_instr_n;
    logic        out_misalign_n;

    logic [63:0] redir_tgt;
    logic [63:0] drain_tgt;
    logic        redir_mis;
    logic        drain_mis;

    assign ireq_valid = ((state == FETCH) || (state == DRAIN)) && !reset;
    assign ireq_addr  = req_addr;
    assign dbg_state  = state;

    // Redirect target as used by the FSM; without the trap the low bits are
    // simply cleared, so the misaligned flags are constant 0.
    always_comb begin
        redir_tgt = TRAP_EN ? redirect_pc : {redirect_pc[63:2], 2'b00};
        drain_tgt = redirect_valid ? redir_tgt : next_pc;
        redir_mis = TRAP_EN && (redir_tgt[1:0] != 2'b00);
        drain_mis = TRAP_EN && (drain_tgt[1:0] != 2'b00);
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n        = state;
        req_addr_n     = req_addr;
        next_pc_n      = next_pc;
        out_valid_n    = out_valid;
        out_pc_n       = out_pc;
        out_instr_n    = out_instr;
        out_misalign_n = out_misalign;
        unique case (state)
            FETCH: begin
                if (iresp_data_ok && !redirect_valid) begin
                    out_valid_n    = 1'b1;
                    out_misalign_n = 1'b0;
                    out_pc_n       = req_addr;
                    out_instr_n    = iresp_data;
                    req_addr_n     = req_addr + PC_STEP;
                    state_n        = PRESENT;
                end else if (iresp_data_ok && redirect_valid) begin
                    // Response belongs to the old path: drop it.
                    if (redir_mis) begin
                        out_valid_n    = 1'b1;
                        out_misalign_n = 1'b1;
                        out_pc_n       = redir_tgt;
                        out_instr_n    = 32'd0;
                        state_n        = PRESENT;
                    end else begin
                        req_addr_n = redir_tgt;
                    end
                end else if (redirect_valid) begin
                    // Request still outstanding; it must finish before refetch.
                    next_pc_n = redir_tgt;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                if (iresp_data_ok) begin
                    if (drain_mis) begin
                        out_valid_n    = 1'b1;
                        out_misalign_n = 1'b1;
                        out_pc_n       = drain_tgt;
                        out_instr_n    = 32'd0;
                        state_n        = PRESENT;
                    end else begin
                        req_addr_n = drain_tgt;
                        state_n    = FETCH;
                    end
                end else if (redirect_valid) begin
                    next_pc_n = redir_tgt;
                end
            end
            PRESENT: begin
                if (redirect_valid) begin
                    if (redir_mis) begin
                        out_valid_n    = 1'b1;
                        out_misalign_n = 1'b1;
                        out_pc_n       = redir_tgt;
                        out_instr_n    = 32'd0;
                    end else begin
                        out_valid_n    = 1'b0;
                        out_misalign_n = 1'b0;
                        req_addr_n     = redir_tgt;
                        state_n        = FETCH;
                    end
                end else if (!stall) begin
                    out_valid_n    = 1'b0;
                    out_misalign_n = 1'b0;
                    state_n        = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            req_addr     <= PC_RESET;
            next_pc      <= PC_RESET;
            out_valid    <= 1'b0;
            out_pc       <= 64'd0;
            out_instr    <= 32'd0;
            out_misalign <= 1'b0;
        end else begin
            state        <= state_n;
            req_addr     <= req_addr_n;
            next_pc      <= next_pc_n;
            out_valid    <= out_valid_n;
            out_pc       <= out_pc_n;
            out_instr    <= out_instr_n;
            out_misalign <= out_misalign_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Inputs change 1 time unit after a rising
// edge and are sampled at the next one; outputs are checked in that same window.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'd0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign),
        .dbg_state      (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_data_ok(input logic [31:0] d);
        iresp_data_ok = 1'b1;
        iresp_data    = d;
        tick();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'd0;
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
        n_vec++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL rst_out_pc: got %0h want 0", out_pc); end
        n_vec++; if (out_instr !== 32'd0) begin n_err++; $display("FAIL rst_out_instr: got %0h want 0", out_instr); end
        n_vec++; if (out_misalign !== 1'b0) begin n_err++; $display("FAIL rst_out_misalign: got %0h want 0", out_misalign); end
        n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL rst_ireq_valid_in_reset: got %0h want 0", ireq_valid); end
        n_vec++; if (ireq_addr !== 64'h8000_0000) begin n_err++; $display("FAIL rst_ireq_addr: got %0h want 80000000", ireq_addr); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0h want 0", dbg_state); end
        reset = 1'b0;
        #1;
        n_vec++; if (ireq_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_req: got %0h want 1", ireq_valid); end
    endtask

    // Three back-to-back sequential fetches, bus answers 2 cycles after request.
    task automatic test_sequential();
        logic [63:0] addrs [3];
        logic [31:0] words [3];
        addrs[0] = 64'h8000_0000; words[0] = 32'h1111_0013;
        addrs[1] = 64'h8000_0004; words[1] = 32'h2222_0093;
        addrs[2] = 64'h8000_0008; words[2] = 32'h3333_0113;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== addrs[i]) begin n_err++; $display("FAIL seq_req[%0d]: got v=%0h a=%0h want v=1 a=%0h", i, ireq_valid, ireq_addr, addrs[i]); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL seq_idle_valid[%0d]: got %0h want 0", i, out_valid); end
            tick();
            n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== addrs[i]) begin n_err++; $display("FAIL seq_req_hold[%0d]: got v=%0h a=%0h want v=1 a=%0h", i, ireq_valid, ireq_addr, addrs[i]); end
            pulse_data_ok(words[i]);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL seq_out_valid[%0d]: got %0h want 1", i, out_valid); end
            n_vec++; if (out_pc !== addrs[i]) begin n_err++; $display("FAIL seq_out_pc[%0d]: got %0h want %0h", i, out_pc, addrs[i]); end
            n_vec++; if (out_instr !== words[i]) begin n_err++; $display("FAIL seq_out_instr[%0d]: got %0h want %0h", i, out_instr, words[i]); end
            n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL seq_no_req_present[%0d]: got %0h want 0", i, ireq_valid); end
            n_vec++; if (out_misalign !== 1'b0) begin n_err++; $display("FAIL seq_misalign[%0d]: got %0h want 0", i, out_misalign); end
            tick();
        end
    endtask

    // Hold the entry at 8000_000C for 5 stalled cycles.
    task automatic test_stall();
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_000C) begin n_err++; $display("FAIL stall_req: got v=%0h a=%0h want v=1 a=8000000c", ireq_valid, ireq_addr); end
        tick();
        stall = 1'b1;
        pulse_data_ok(32'h4444_0193);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_000C || out_instr !== 32'h4444_0193) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%0h pc=%0h i=%0h want v=1 pc=8000000c i=44440193", i, out_valid, out_pc, out_instr); end
            n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_req[%0d]: got %0h want 0", i, ireq_valid); end
        end
        stall = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_consumed: got %0h want 0", out_valid); end
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin n_err++; $display("FAIL stall_next_req: got v=%0h a=%0h want v=1 a=80000010", ireq_valid, ireq_addr); end
    endtask

    // Redirect while the request for 8000_0010 is in flight.
    task automatic test_redirect_inflight();
        pulse_redirect(64'h8000_1000);
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin n_err++; $display("FAIL drain_addr_hold0: got v=%0h a=%0h want v=1 a=80000010", ireq_valid, ireq_addr); end
        tick();
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin n_err++; $display("FAIL drain_addr_hold1: got v=%0h a=%0h want v=1 a=80000010", ireq_valid, ireq_addr); end
        n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL drain_state: got %0h want 1", dbg_state); end
        pulse_data_ok(32'hDEAD_BEEF);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_stale_dropped: got %0h want 0", out_valid); end
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin n_err++; $display("FAIL drain_refetch: got v=%0h a=%0h want v=1 a=80001000", ireq_valid, ireq_addr); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_never_presented: got %0h want 0", out_valid); end
    endtask

    // Redirect in the same cycle as data_ok for 8000_1000.
    task automatic test_redirect_with_data();
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        tick();
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin n_err++; $display("FAIL same_cycle_refetch: got v=%0h a=%0h want v=1 a=80002000", ireq_valid, ireq_addr); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL same_cycle_valid: got %0h want 0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL same_cycle_valid_late: got %0h want 0", out_valid); end
    endtask

    // Two redirects while draining 8000_2000, then a redirect under stall.
    task automatic test_double_redirect();
        pulse_redirect(64'h8000_3000);
        n_vec++; if (ireq_addr !== 64'h8000_2000) begin n_err++; $display("FAIL dbl_drain_addr0: got %0h want 80002000", ireq_addr); end
        tick();
        pulse_redirect(64'h8000_4000);
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin n_err++; $display("FAIL dbl_drain_addr1: got v=%0h a=%0h want v=1 a=80002000", ireq_valid, ireq_addr); end
        pulse_data_ok(32'hBAD0_0002);
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_4000) begin n_err++; $display("FAIL dbl_latest_wins: got v=%0h a=%0h want v=1 a=80004000", ireq_valid, ireq_addr); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dbl_valid: got %0h want 0", out_valid); end
        tick();
        pulse_data_ok(32'h5555_0213);
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_4000 || out_instr !== 32'h5555_0213) begin n_err++; $display("FAIL dbl_present: got v=%0h pc=%0h i=%0h want v=1 pc=80004000 i=55550213", out_valid, out_pc, out_instr); end
        stall = 1'b1;
        pulse_redirect(64'h8000_5000);
        stall = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_over_stall_valid: got %0h want 0", out_valid); end
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_5000) begin n_err++; $display("FAIL redir_over_stall_req: got v=%0h a=%0h want v=1 a=80005000", ireq_valid, ireq_addr); end
    endtask

    // PC increment wraps modulo 2^64.
    task automatic test_wrap();
        iresp_data_ok  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        n_vec++; if (ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_req: got %0h want fffffffffffffffc", ireq_addr); end
        tick();
        pulse_data_ok(32'h6666_0293);
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_present: got v=%0h pc=%0h want v=1 pc=fffffffffffffffc", out_valid, out_pc); end
        tick();
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0) begin n_err++; $display("FAIL wrap_next: got v=%0h a=%0h want v=1 a=0", ireq_valid, ireq_addr); end
    endtask

    // Redirect to a misaligned target together with data_ok (no drain needed).
    task automatic test_misalign();
        iresp_data_ok  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0002;
        tick();
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_vec++; if (out_valid !== 1'b1 || out_misalign !== 1'b1) begin n_err++; $display("FAIL mis_marker: got v=%0h m=%0h want v=1 m=1", out_valid, out_misalign); end
        n_vec++; if (out_pc !== 64'h8000_0002 || out_instr !== 32'd0) begin n_err++; $display("FAIL mis_payload: got pc=%0h i=%0h want pc=80000002 i=0", out_pc, out_instr); end
        n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_req: got %0h want 0", ireq_valid); end
        tick();
`else
        n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000) begin n_err++; $display("FAIL mis_aligned_req: got v=%0h a=%0h want v=1 a=80000000", ireq_valid, ireq_addr); end
        n_vec++; if (out_valid !== 1'b0 || out_misalign !== 1'b0) begin n_err++; $display("FAIL mis_no_marker: got v=%0h m=%0h want v=0 m=0", out_valid, out_misalign); end
`endif
    endtask

    // Reset asserted together with data_ok: the response must be ignored.
    task automatic test_reset_mid();
        stall = 1'b0;
        tick();
        reset         = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h7777_0313;
        tick();
        iresp_data_ok = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got v=%0h rq=%0h want 0 0", out_valid, ireq_valid); end
        n_vec++; if (ireq_addr !== 64'h8000_0000) begin n_err++; $display("FAIL rstmid_addr: got %0h want 80000000", ireq_addr); end
        reset = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0 || ireq_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_after: got v=%0h rq=%0h want v=0 rq=1", out_valid, ireq_valid); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_inflight();
        test_redirect_with_data();
        test_double_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
